// File: rtl/alu_pkg.sv
// Shared types for the ALU writeback stage: opcodes, compare codes, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'd0,
    OP_OR    = 4'd1,
    OP_ADD   = 4'd2,
    OP_SUB   = 4'd3,
    OP_ADDI  = 4'd4,
    OP_MOVB  = 4'd5,
    OP_MOVA  = 4'd6,
    OP_CMP   = 4'd7,
    OP_SHIFT = 4'd8,
    OP_M9    = 4'd9,
    OP_M10   = 4'd10,
    OP_M11   = 4'd11,
    OP_M12   = 4'd12,
    OP_STORE = 4'd13,
    OP_LOAD  = 4'd14,
    OP_HALT  = 4'd15
  } opcode_t;

  localparam logic [1:0] CMP_LT   = 2'b00;
  localparam logic [1:0] CMP_GT   = 2'b01;
  localparam logic [1:0] CMP_EQ   = 2'b10;
  localparam logic [1:0] CMP_NONE = 2'b11;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    WAIT_LOAD = 2'd1,
    HALTED    = 2'd2
  } wb_state_t;

  // Arithmetic/shift ops produce a meaningful carry_out worth latching.
  function automatic logic op_sets_carry(input opcode_t op);
    return op inside {OP_ADD, OP_SUB, OP_ADDI, OP_SHIFT};
  endfunction

  // Every op whose ALU data_out is committed straight to ex_dst.
  function automatic logic op_writes_reg(input opcode_t op);
    return op_sets_carry(op) ||
           (op inside {OP_AND, OP_OR, OP_MOVB, OP_MOVA, OP_M9, OP_M10, OP_M11, OP_M12});
  endfunction

endpackage

// File: rtl/reg_array.sv
// Architectural register file: 1 write port, 2 combinational read ports.
// Latency: write lands on the clock edge; reads are same-cycle combinational, no bypass.
// Backpressure: none; a write is taken whenever i_we is high and the index is in range.
module reg_array #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_rd_addr_a,
  input  logic [ADDR_W-1:0] i_rd_addr_b,
  output logic [DATA_W-1:0] o_rd_data_a,
  output logic [DATA_W-1:0] o_rd_data_b
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  // Storage: async clear, otherwise write the addressed entry; out-of-range indices are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (i_we && (int'(i_waddr) < NUM_REGS)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Out-of-range reads (only possible for non-power-of-2 sizes) return zero.
  assign o_rd_data_a = (int'(i_rd_addr_a) < NUM_REGS) ? r_mem[i_rd_addr_a] : '0;
  assign o_rd_data_b = (int'(i_rd_addr_b) < NUM_REGS) ? r_mem[i_rd_addr_b] : '0;

endmodule

// File: rtl/alu_writeback.sv
// Commits ALU results/loads to the register file, latches carry/compare flags, sequences load and halt.
// Latency: accepted op visible on rd_data/flags 1 cycle later; wb_* report the write 1 cycle later.
// Backpressure: stall is high while waiting for load data or halted; ex_valid is ignored then.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic [3:0]        ex_instr,
  input  logic [ADDR_W-1:0] ex_dst,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              ex_carry,
  input  logic [1:0]        ex_cmp,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              carry_flag,
  output logic [1:0]        cmp_flag,
  output logic              stall,
  output logic              halted,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data
);

  wb_state_t         r_state;
  logic              r_carry;
  logic [1:0]        r_cmp;
  logic [ADDR_W-1:0] r_pend_dst;
  logic              r_wb_vld;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;

  opcode_t           w_op;
  logic              w_accept;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  assign w_op     = opcode_t'(ex_instr);
  assign w_accept = ex_valid && (r_state == RUN);

  // Select the single register write this cycle: an accepted ALU op, or the returning load.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = ex_dst;
    w_wdata = ex_data;
    if (w_accept && op_writes_reg(w_op)) begin
      w_we = 1'b1;
    end else if ((r_state == WAIT_LOAD) && mem_valid) begin
      w_we    = 1'b1;
      w_waddr = r_pend_dst;
      w_wdata = mem_data;
    end
    // Dropped writes must not be reported on the wb_* port either.
    if (int'(w_waddr) >= NUM_REGS) w_we = 1'b0;
  end

  reg_array #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W)
  ) u_reg_array (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_we        (w_we),
    .i_waddr     (w_waddr),
    .i_wdata     (w_wdata),
    .i_rd_addr_a (rd_addr_a),
    .i_rd_addr_b (rd_addr_b),
    .o_rd_data_a (rd_data_a),
    .o_rd_data_b (rd_data_b)
  );

  // FSM, flag latching and the registered writeback report.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= RUN;
      r_carry    <= 1'b0;
      r_cmp      <= CMP_NONE;
      r_pend_dst <= '0;
      r_wb_vld   <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_vld <= w_we;
      if (w_we) begin
        r_wb_addr <= w_waddr;
        r_wb_data <= w_wdata;
      end
      case (r_state)
        RUN: begin
          if (ex_valid) begin
            if (op_sets_carry(w_op)) r_carry <= ex_carry;
            // Only an explicit compare updates cmp_flag, so the ALU idle code never leaks in.
            if (w_op == OP_CMP) r_cmp <= ex_cmp;
            if (w_op == OP_LOAD) begin
              r_pend_dst <= ex_dst;
              r_state    <= WAIT_LOAD;
            end
            if (w_op == OP_HALT) r_state <= HALTED;
          end
        end
        WAIT_LOAD: begin
          if (mem_valid) r_state <= RUN;
        end
        HALTED: begin
          r_state <= HALTED;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign carry_flag = r_carry;
  assign cmp_flag   = r_cmp;
  assign stall      = (r_state == WAIT_LOAD) || (r_state == HALTED);
  assign halted     = (r_state == HALTED);
  assign wb_valid   = r_wb_vld;
  assign wb_addr    = r_wb_addr;
  assign wb_data    = r_wb_data;

endmodule
